thermometer_encode: RTL

//  Converts a 16-bit thermometer code back to a 4-bit level. It is the inverse of the

---
 rtl/thermometer_pkg.sv | 35 +++
 rtl/thermometer_bubble_fix.sv | 30 +++
 rtl/thermometer_encode.sv | 104 ++++++++++
 3 files changed

// File: rtl/thermometer_pkg.sv
// Shared thermometer-code constants and helpers, used by both the bar-graph
// decoder and the thermometer-to-level encoder.
package thermometer_pkg;

    localparam int THERM_W         = 16;
    localparam int THERM_LVL_W     = 4;
    localparam int THERM_ERR_CNT_W = 8;

    // Legal code: a non-empty run of ones starting at bit 0, zeros above it.
    function automatic bit is_thermometer(input logic [THERM_W-1:0] code);
        bit seen_zero;
        seen_zero = 1'b0;
        for (int i = 0; i < THERM_W; i++) begin
            if (!code[i]) begin
                seen_zero = 1'b1;
            end else if (seen_zero) begin
                return 1'b0;
            end
        end
        return code[0];
    endfunction

    // Index of the highest set bit; 0 for an all-zero word.
    function automatic logic [THERM_LVL_W-1:0] therm_to_level(input logic [THERM_W-1:0] code);
        logic [THERM_LVL_W-1:0] level;
        level = '0;
        for (int i = 0; i < THERM_W; i++) begin
            if (code[i]) begin
                level = THERM_LVL_W'(i);
            end
        end
        return level;
    endfunction

endpackage

// File: rtl/thermometer_bubble_fix.sv
// Combinational bubble detector and 3-input majority corrector for a raw
// thermometer word.
module thermometer_bubble_fix
    import thermometer_pkg::*;
#(
    parameter int WIDTH = THERM_W
) (
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] corr,
    output logic             bubble
);

    // Implicit neighbours: a one below bit 0 and a zero above the top bit.
    logic [WIDTH+1:0] ext;
    assign ext = {1'b0, raw, 1'b1};

    always_comb begin
        corr   = '0;
        bubble = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            corr[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
        for (int i = 1; i < WIDTH; i++) begin
            if (raw[i] && !raw[i-1]) begin
                bubble = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thermometer_encode.sv
// Two-stage valid/ready pipeline converting a thermometer code to a level,
// with bubble correction, error flags and a saturating error counter.
module thermometer_encode
    import thermometer_pkg::*;
#(
    parameter int WIDTH     = THERM_W,
    parameter int LVL_W     = THERM_LVL_W,
    parameter int ERR_CNT_W = THERM_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LVL_W-1:0]     out_level,
    output logic                 out_bubble,
    output logic                 out_zero,
    input  logic                 err_clear,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_corr;
    logic             s1_bubble;

    logic [WIDTH-1:0] fix_corr;
    logic             fix_bubble;

    logic             adv1;
    logic             adv2;

    logic [LVL_W-1:0] enc_level;
    logic             enc_zero;

    logic             err_event;

    thermometer_bubble_fix #(
        .WIDTH (WIDTH)
    ) u_bubble_fix (
        .raw    (in_code),
        .corr   (fix_corr),
        .bubble (fix_bubble)
    );

    // Out stage is the output register itself, so out_valid doubles as s2_valid.
    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_corr   <= '0;
            s1_bubble <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_corr   <= fix_corr;
                s1_bubble <= fix_bubble;
            end
        end
    end

    always_comb begin
        enc_level = '0;
        enc_zero  = (s1_corr == '0);
        for (int i = 0; i < WIDTH; i++) begin
            if (s1_corr[i]) begin
                enc_level = LVL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_level  <= '0;
            out_bubble <= 1'b0;
            out_zero   <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_level  <= enc_level;
                out_bubble <= s1_bubble;
                out_zero   <= enc_zero;
            end
        end
    end

    assign err_event = out_valid && out_ready && (out_bubble || out_zero);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (err_clear) begin
            err_count <= '0;
        end else if (err_event && (err_count != '1)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule
